// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small first-word-fall-through
// receive FIFO, with sticky framing-error and overrun flags.
module uart_rx_fifo #(
  parameter  int CLK_DIV    = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             rx,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] fifo_count,
  output logic             frame_err,
  output logic             overrun
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic              rx_meta_q, rx_sync_q;
  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              frame_err_q, overrun_q;

  logic stop_sample, push, frame_evt, pop, full, wr_en, ovr_evt;

  // Two-flop synchroniser; resets to the idle-high line level.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Deframing FSM: counts baud ticks down to each mid-bit sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (!ena) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_q <= S_START;
            baud_q  <= BAUD_HALF;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            if (!rx_sync_q) begin
              state_q <= S_DATA;
              baud_q  <= BAUD_FULL;
              bit_q   <= '0;
            end else begin
              state_q <= S_IDLE;  // glitch shorter than half a bit
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            baud_q  <= BAUD_FULL;
            if (bit_q == 3'd7) state_q <= S_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (baud_q == '0) state_q <= rx_sync_q ? S_IDLE : S_WAIT_HIGH;
          else              baud_q  <= baud_q - BAUD_W'(1);
        end
        S_WAIT_HIGH: begin
          if (rx_sync_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stop_sample = ena && (state_q == S_STOP) && (baud_q == '0);
  assign push        = stop_sample && rx_sync_q;
  assign frame_evt   = stop_sample && !rx_sync_q;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = rd_en && (count_q != '0);
  assign wr_en   = push && (!full || pop);
  assign ovr_evt = push && full && !pop;

  // Next occupancy from the accepted write/read pair.
  // NOTE: always_comb assigns a default first so no path leaves count_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port.
  // NOTE: the data array has no reset; empty entries are never visible
  // because rd_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Sticky error flags; a new event in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_evt | (frame_err_q & ~clr_err);
      overrun_q   <= ovr_evt   | (overrun_q   & ~clr_err);
    end
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: reset, directed frames, a vector
// table, multi-cycle corner cases and random traffic against a queue model.
module tb_uart_rx_fifo;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic             rx = 1'b1;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             frame_err;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  int push_lat = -1;

  // Reference model: byte queue plus two sticky flags.
  logic [7:0] mq[$];
  bit         m_ferr, m_ovr;

  typedef struct {
    logic [7:0]       data;
    logic             stop_ok;
    logic             rd_after;
    logic [7:0]       exp_head;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ferr;
    logic             exp_ovr;
  } vec_t;

  vec_t vecs[7];

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx        (rx),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame; a bad frame can keep the line low afterwards.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gap, input int hold = 0);
    logic [9:0] f;
    f = {stop_ok ? 1'b1 : 1'b0, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = f[b];
      repeat (CLK_DIV) tick();
    end
    if (!stop_ok) repeat (hold) tick();
    rx = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic check_model(input string tag);
    sample();
    check({tag, "_count"}, fifo_count, mq.size());
    check({tag, "_valid"}, rd_valid, (mq.size() != 0));
    check({tag, "_data"}, rd_data, (mq.size() != 0) ? mq[0] : 8'h00);
    check({tag, "_ferr"}, frame_err, m_ferr);
    check({tag, "_ovr"}, overrun, m_ovr);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_data"}, rd_data, 8'h00);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    // Expected table, starting from an empty FIFO with clear flags.
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'hA5, 3'd2, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 8'hA5, 3'd2, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hA5, 3'd3, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 8'hA5, 3'd4, 1'b1, 1'b0};
    vecs[5] = '{8'h42, 1'b1, 1'b1, 8'hA5, 3'd4, 1'b1, 1'b1};
    vecs[6] = '{8'h11, 1'b1, 1'b0, 8'h3C, 3'd4, 1'b1, 1'b1};

    // Reset and long idle.
    repeat (3) tick();
    rst_n = 1'b1;
    sample();
    check_reset_state("reset");
    repeat (1000) tick();
    sample();
    check_reset_state("idle1000");

    // 0xA5 with first-push latency measured from the start edge.
    tick();
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        for (int k = 1; k <= 200; k++) begin
          tick();
          if (rd_valid) begin
            push_lat = k;
            break;
          end
        end
      end
    join
    check("a5_latency_ok", (push_lat >= 1 && push_lat <= CLK_DIV * 10 + 4), 1);
    if (push_lat < 1) push_lat = 155;
    sample();
    check("a5_data", rd_data, 8'hA5);
    check("a5_count", fifo_count, 1);
    pop();
    sample();
    check("a5_pop_count", fifo_count, 0);
    check("a5_pop_valid", rd_valid, 0);

    // Bad stop bit followed by a held-low line.
    tick();
    send_frame(8'h00, 1'b0, 8, 48);
    sample();
    check("break_ferr", frame_err, 1);
    check("break_count", fifo_count, 0);
    tick();
    send_frame(8'h3C, 1'b1, 4);
    sample();
    check("after_break_data", rd_data, 8'h3C);
    tick();
    clear_flags();
    sample();
    check("clr_ferr", frame_err, 0);
    tick();
    pop();

    // Short start glitch must not produce a byte.
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    sample();
    check("glitch_count", fifo_count, 0);
    check("glitch_ferr", frame_err, 0);
    tick();
    send_frame(8'h7E, 1'b1, 4);
    sample();
    check("after_glitch_data", rd_data, 8'h7E);
    tick();
    pop();

    // Vector table.
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, 4);
      sample();
      check($sformatf("vec%0d_head", i), rd_data, vecs[i].exp_head);
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), overrun, vecs[i].exp_ovr);
      tick();
      if (vecs[i].rd_after) pop();
    end
    clear_flags();
    sample();
    check("vec_clr_ferr", frame_err, 0);
    check("vec_clr_ovr", overrun, 0);
    begin
      logic [7:0] drain_exp [4];
      drain_exp = '{8'h3C, 8'hFF, 8'h81, 8'h11};
      for (int i = 0; i < 4; i++) begin
        sample();
        check($sformatf("vec_drain%0d", i), rd_data, drain_exp[i]);
        tick();
        pop();
      end
    end
    pop();  // read while empty must be ignored
    sample();
    check("underflow_count", fifo_count, 0);
    check("underflow_valid", rd_valid, 0);

    // Five back-to-back bytes into a depth-4 FIFO.
    tick();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
    repeat (4) tick();
    sample();
    check("b2b_count", fifo_count, 4);
    check("b2b_ovr", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      sample();
      check($sformatf("b2b_read%0d", i), rd_data, 8'(i));
      tick();
      pop();
    end
    clear_flags();

    // Push and pop in the same cycle while full: no overrun.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 2);
    fork
      send_frame(8'h14, 1'b1, 0);
      begin
        repeat (push_lat - 1) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
      end
    join
    repeat (2) tick();
    sample();
    check("full_pushpop_count", fifo_count, 4);
    check("full_pushpop_ovr", overrun, 0);
    for (int i = 1; i <= 4; i++) begin
      sample();
      check($sformatf("full_pushpop_read%0d", i), rd_data, 8'h10 + 8'(i));
      tick();
      pop();
    end

    // A frame error coinciding with clr_err leaves the flag set.
    send_frame(8'h00, 1'b0, 4);
    fork
      send_frame(8'h00, 1'b0, 0);
      begin
        repeat (push_lat - 1) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
      end
    join
    repeat (2) tick();
    sample();
    check("set_wins_ferr", frame_err, 1);
    tick();
    clear_flags();

    // Random traffic against the queue model.
    mq.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    check_model("rand_start");
    tick();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit         ok;
      int         npop;
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop();
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        clear_flags();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      d  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(d, ok, $urandom_range(1, 5));
      if (!ok)                 m_ferr = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(d);
      else                     m_ovr = 1'b1;
      check_model($sformatf("rand%0d", i));
      tick();
    end

    // Asynchronous reset mid-frame with bytes queued and an error flagged.
    send_frame(8'h00, 1'b0, 4);
    send_frame(8'h21, 1'b1, 2);
    send_frame(8'h22, 1'b1, 2);
    rx = 1'b0;
    repeat (CLK_DIV) tick();
    rx = 1'b1;
    repeat (CLK_DIV * 3 + CLK_DIV / 2) tick();
    rst_n = 1'b0;
    #2;
    check_reset_state("async_rst");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    send_frame(8'h5A, 1'b1, 4);
    sample();
    check("after_rst_data", rd_data, 8'h5A);
    check("after_rst_count", fifo_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on the whole run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
